// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: FSM state encodings and write-back source select shared by WB, control and forwarding logic.
package mem_wb_stage_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_MEM  = 2'd1,
        WB_SRC_LINK = 2'd2
    } wb_src_e;

    // Link beats load beats ALU.
    function automatic wb_src_e wb_src_sel(input logic link, input logic mem_to_reg);
        return link ? WB_SRC_LINK : (mem_to_reg ? WB_SRC_MEM : WB_SRC_ALU);
    endfunction

endpackage

// File: rtl/mem_wb_stage_wb_mux.sv
// wb_mux: combinational 3-way write-back source select.
module wb_mux
    import mem_wb_stage_pkg::*;
#(
    parameter int NB_WIDTH = 32
) (
    input  wb_src_e             i_sel,
    input  logic [NB_WIDTH-1:0] i_alu_data,
    input  logic [NB_WIDTH-1:0] i_mem_data,
    input  logic [NB_WIDTH-1:0] i_link_data,
    output logic [NB_WIDTH-1:0] o_data
);

    always_comb begin
        o_data = (i_sel == WB_SRC_LINK) ? i_link_data :
                 (i_sel == WB_SRC_MEM)  ? i_mem_data  : i_alu_data;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, write-back select, HALT FSM and retired-instruction counter.
// Optional macro RETIRE_COUNTER_EN enables the retired-instruction counter (tied to 0 otherwise).
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int NB_WIDTH = 32,
    parameter int NB_REG   = 5,
    parameter int NB_CNT   = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_reg_write,
    input  logic                i_mem_to_reg,
    input  logic                i_link,
    input  logic                i_halt,
    input  logic [NB_WIDTH-1:0] i_alu_result,
    input  logic [NB_WIDTH-1:0] i_return_addr,
    input  logic [NB_REG-1:0]   i_rd_addr,
    input  logic [NB_WIDTH-1:0] i_mem_read_data,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_dunit_clear,
    output logic                o_wb_we,
    output logic [NB_REG-1:0]   o_wb_addr,
    output logic [NB_WIDTH-1:0] o_wb_data,
    output logic                o_fwd_valid,
    output logic [NB_REG-1:0]   o_fwd_addr,
    output logic [NB_WIDTH-1:0] o_fwd_data,
    output logic                o_halted,
    output logic [NB_CNT-1:0]   o_retired_count
);

    logic                valid_q;
    logic                reg_write_q;
    logic                mem_to_reg_q;
    logic                link_q;
    logic                halt_q;
    logic [NB_WIDTH-1:0] alu_q;
    logic [NB_WIDTH-1:0] ret_q;
    logic [NB_REG-1:0]   rd_q;
    logic                hold_vld;
    logic [NB_WIDTH-1:0] hold_data;
    logic [NB_WIDTH-1:0] load_data;
    logic [NB_WIDTH-1:0] wb_data;
    state_e              state;
    state_e              state_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            halt_q       <= 1'b0;
            alu_q        <= '0;
            ret_q        <= '0;
            rd_q         <= '0;
        end else if (i_flush) begin
            valid_q      <= 1'b0;
        end else if (!i_stall) begin
            valid_q      <= i_valid;
            reg_write_q  <= i_reg_write;
            mem_to_reg_q <= i_mem_to_reg;
            link_q       <= i_link;
            halt_q       <= i_halt;
            alu_q        <= i_alu_result;
            ret_q        <= i_return_addr;
            rd_q         <= i_rd_addr;
        end
    end

    // MEM keeps advancing during a stall, so its load data is snapshotted on the first stalled edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (!i_stall) begin
            hold_vld  <= 1'b0;
        end else if (!hold_vld) begin
            hold_vld  <= 1'b1;
            hold_data <= i_mem_read_data;
        end
    end

    assign load_data = hold_vld ? hold_data : i_mem_read_data;

    wb_mux #(.NB_WIDTH(NB_WIDTH)) u_wb_mux (
        .i_sel       (wb_src_sel(link_q, mem_to_reg_q)),
        .i_alu_data  (alu_q),
        .i_mem_data  (load_data),
        .i_link_data (ret_q),
        .o_data      (wb_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == ST_RUN) ? ((valid_q && halt_q) ? ST_HALTED : ST_RUN) :
                                        (i_dunit_clear ? ST_RUN : ST_HALTED);
    end

`ifdef RETIRE_COUNTER_EN
    logic [NB_CNT-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_dunit_clear)                        cnt_q <= '0;
        else if (valid_q && state == ST_RUN && !i_stall)     cnt_q <= cnt_q + 1'b1;
    end

    assign o_retired_count = cnt_q;
`else
    assign o_retired_count = '0;
`endif

    assign o_wb_we     = valid_q && reg_write_q && (rd_q != '0) && (state == ST_RUN);
    assign o_wb_addr   = rd_q;
    assign o_wb_data   = wb_data;
    assign o_fwd_valid = o_wb_we;
    assign o_fwd_addr  = rd_q;
    assign o_fwd_data  = wb_data;
    assign o_halted    = (state == ST_HALTED);

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scoreboard bench for mem_wb_stage (counter checks follow RETIRE_COUNTER_EN).
module tb_mem_wb_stage;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        link;
        logic        halt;
        logic [31:0] alu;
        logic [31:0] ret;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        halted;
        logic [3:0]  cnt;
        logic        chk_ad;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, reg_write = 1'b0, mem_to_reg = 1'b0, link = 1'b0, halt = 1'b0;
    logic [31:0] alu_result = '0, return_addr = '0, mem_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        stall = 1'b0, flush = 1'b0, dclear = 1'b0;
    logic        wb_we, fwd_valid, halted;
    logic [4:0]  wb_addr, fwd_addr;
    logic [31:0] wb_data, fwd_data;
    logic [3:0]  retired;

    int   n_eval = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_wb_stage #(.NB_WIDTH(32), .NB_REG(5), .NB_CNT(4)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_valid         (valid),
        .i_reg_write     (reg_write),
        .i_mem_to_reg    (mem_to_reg),
        .i_link          (link),
        .i_halt          (halt),
        .i_alu_result    (alu_result),
        .i_return_addr   (return_addr),
        .i_rd_addr       (rd_addr),
        .i_mem_read_data (mem_data),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_dunit_clear   (dclear),
        .o_wb_we         (wb_we),
        .o_wb_addr       (wb_addr),
        .o_wb_data       (wb_data),
        .o_fwd_valid     (fwd_valid),
        .o_fwd_addr      (fwd_addr),
        .o_fwd_data      (fwd_data),
        .o_halted        (halted),
        .o_retired_count (retired)
    );

    function automatic logic [3:0] ec(input int n);
`ifdef RETIRE_COUNTER_EN
        return 4'(n);
`else
        return 4'd0;
`endif
    endfunction

    function automatic instr_t ins(input logic v, rw, m2r, lk, h, input logic [31:0] a, r, input logic [4:0] d);
        return '{valid: v, rw: rw, m2r: m2r, link: lk, halt: h, alu: a, ret: r, rd: d};
    endfunction

    function automatic exp_t ex(input logic we, input logic [4:0] a, input logic [31:0] d,
                                input logic h, input int c, input logic chk_ad);
        return '{we: we, addr: a, data: d, halted: h, cnt: ec(c), chk_ad: chk_ad};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        exp_t x;
        n_eval++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard: observed %0d entries expected >0", sb.size());
            return;
        end
        x = sb.pop_front();
        chk("wb_we", 32'(wb_we), 32'(x.we));
        chk("fwd_valid", 32'(fwd_valid), 32'(x.we));
        chk("halted", 32'(halted), 32'(x.halted));
        chk("retired", 32'(retired), 32'(x.cnt));
        if (x.chk_ad) begin
            chk("wb_addr", 32'(wb_addr), 32'(x.addr));
            chk("fwd_addr", 32'(fwd_addr), 32'(x.addr));
            chk("wb_data", wb_data, x.data);
            chk("fwd_data", fwd_data, x.data);
        end
    endtask

    // mem_after models MEM's registered load data changing just after the edge.
    task automatic step(input instr_t in, input logic st, fl, clr, rs,
                        input logic [31:0] mem_after, input exp_t e);
        @(negedge clk);
        valid = in.valid; reg_write = in.rw; mem_to_reg = in.m2r; link = in.link; halt = in.halt;
        alu_result = in.alu; return_addr = in.ret; rd_addr = in.rd;
        stall = st; flush = fl; dclear = clr; rst = rs;
        sb.push_back(e);
        @(posedge clk);
        #1 mem_data = mem_after;
        #1 compare();
    endtask

    initial begin
        instr_t bub;
        bub = '0;
        step(bub, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, ex(1'b0, 5'd0, 32'h0, 1'b0, 0, 1'b1));
        step(bub, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, ex(1'b0, 5'd0, 32'h0, 1'b0, 0, 1'b1));
        // ALU write
        step(ins(1, 1, 0, 0, 0, 32'h1234, 0, 5'd5), 0, 0, 0, 0, 32'h0,
             ex(1'b1, 5'd5, 32'h0000_1234, 1'b0, 0, 1'b1));
        // Load, then 2-cycle stall while MEM data moves on
        step(ins(1, 1, 1, 0, 0, 32'hDEAD, 0, 5'd8), 0, 0, 0, 0, 32'hFFFF_FF80,
             ex(1'b1, 5'd8, 32'hFFFF_FF80, 1'b0, 1, 1'b1));
        step(bub, 1, 0, 0, 0, 32'h0, ex(1'b1, 5'd8, 32'hFFFF_FF80, 1'b0, 1, 1'b1));
        step(bub, 1, 0, 0, 0, 32'h0, ex(1'b1, 5'd8, 32'hFFFF_FF80, 1'b0, 1, 1'b1));
        // r0 write suppressed
        step(ins(1, 1, 0, 0, 0, 32'h55, 0, 5'd0), 0, 0, 0, 0, 32'h0,
             ex(1'b0, 5'd0, 32'h55, 1'b0, 2, 1'b1));
        // Link beats mem_to_reg
        step(ins(1, 1, 1, 1, 0, 32'h99, 32'h40, 5'd31), 0, 0, 0, 0, 32'h777,
             ex(1'b1, 5'd31, 32'h40, 1'b0, 3, 1'b1));
        // Flush + stall: bubble, counter unchanged
        step(ins(1, 1, 0, 0, 0, 32'h7, 0, 5'd3), 1, 1, 0, 0, 32'h0,
             ex(1'b0, 5'd0, 32'h0, 1'b0, 3, 1'b0));
        step(bub, 0, 0, 0, 0, 32'h0, ex(1'b0, 5'd0, 32'h0, 1'b0, 3, 1'b1));
        // Clear in RUN only zeroes the counter
        step(bub, 0, 0, 1, 0, 32'h0, ex(1'b0, 5'd0, 32'h0, 1'b0, 0, 1'b1));
        // Three instructions then HALT
        step(ins(1, 1, 0, 0, 0, 32'h1, 0, 5'd1), 0, 0, 0, 0, 32'h0, ex(1'b1, 5'd1, 32'h1, 1'b0, 0, 1'b1));
        step(ins(1, 1, 0, 0, 0, 32'h2, 0, 5'd2), 0, 0, 0, 0, 32'h0, ex(1'b1, 5'd2, 32'h2, 1'b0, 1, 1'b1));
        step(ins(1, 1, 0, 0, 0, 32'h3, 0, 5'd3), 0, 0, 0, 0, 32'h0, ex(1'b1, 5'd3, 32'h3, 1'b0, 2, 1'b1));
        step(ins(1, 0, 0, 0, 1, 32'h4, 0, 5'd4), 0, 0, 0, 0, 32'h0, ex(1'b0, 5'd4, 32'h4, 1'b0, 3, 1'b1));
        step(ins(1, 1, 0, 0, 0, 32'h66, 0, 5'd6), 0, 0, 0, 0, 32'h0, ex(1'b0, 5'd6, 32'h66, 1'b1, 4, 1'b1));
        step(bub, 0, 0, 0, 0, 32'h0, ex(1'b0, 5'd0, 32'h0, 1'b1, 4, 1'b1));
        step(bub, 0, 0, 1, 0, 32'h0, ex(1'b0, 5'd0, 32'h0, 1'b0, 0, 1'b1));
        // 18 back-to-back writes: counter reaches 17, wraps to 1 on 4 bits
        for (int i = 0; i < 18; i++)
            step(ins(1, 1, 0, 0, 0, 32'(i * 3 + 1), 0, 5'(i % 31 + 1)), 0, 0, 0, 0, 32'h0,
                 ex(1'b1, 5'(i % 31 + 1), 32'(i * 3 + 1), 1'b0, i, 1'b1));
        step(bub, 0, 0, 0, 0, 32'h0, ex(1'b0, 5'd0, 32'h0, 1'b0, 18, 1'b1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
